// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcode
// classes and the ALUCtrl encodings also used by the datapath ALU.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_I   = 3'd1,
        C_LW  = 3'd2,
        C_SW  = 3'd3,
        C_BEQ = 3'd4,
        C_ILL = 3'd5
    } iclass_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    function automatic iclass_t classify(input logic [6:0] opc);
        case (opc)
            OPC_R:   return C_R;
            OPC_I:   return C_I;
            OPC_LW:  return C_LW;
            OPC_SW:  return C_SW;
            OPC_BEQ: return C_BEQ;
            default: return C_ILL;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUCtrl decode from instruction class, funct3 and funct7[5].
module alu_decoder
    import ctrl_pkg::*;
(
    input  iclass_t    i_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [3:0] o_alu_ctrl
);

    logic [3:0] w_arith;

    // funct3 map shared by R and I-ALU; SLTU/SLTIU fall back to SLT
    always_comb begin
        w_arith = ALU_ADD;
        case (i_funct3)
            3'b000: w_arith = (i_class == C_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: w_arith = ALU_SLL;
            3'b010: w_arith = ALU_SLT;
            3'b011: w_arith = ALU_SLT;
            3'b100: w_arith = ALU_XOR;
            3'b101: w_arith = i_funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: w_arith = ALU_OR;
            3'b111: w_arith = ALU_AND;
            default: w_arith = ALU_ADD;
        endcase
    end

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_class)
            C_R, C_I: o_alu_ctrl = w_arith;
            C_BEQ:    o_alu_ctrl = ALU_SUB;
            default:  o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-state (IF/ID/EX/MEM/WB) control unit for the RV32I subset datapath.
// Define CTRL_PERF_CNT_EN to add the instret and stall_cnt counter outputs.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        dReady,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [3:0]  ALUCtrl
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] instret,
    output logic [31:0] stall_cnt
`endif
);

    state_t     r_state;
    logic [31:0] r_ir;
    logic       r_br;
    iclass_t    w_class;
    logic [3:0] w_alu_ctrl;
    logic       w_is_mem;
    logic       w_unused_ir;

    assign w_class     = classify(r_ir[6:0]);
    assign w_is_mem    = (w_class == C_LW) || (w_class == C_SW);
    assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

    alu_decoder u_alu_decoder (
        .i_class    (w_class),
        .i_funct3   (r_ir[14:12]),
        .i_funct7b5 (r_ir[30]),
        .o_alu_ctrl (w_alu_ctrl)
    );

    // Decode outputs come straight from IR, so they are stable from ID to WB
    assign ALUCtrl  = (r_state == S_IF) ? 4'b0000 : w_alu_ctrl;
    assign ALUSrc   = (r_state != S_IF) &&
                      (w_class == C_I || w_class == C_LW || w_class == C_SW);
    assign MemToReg = (r_state != S_IF) && (w_class == C_LW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IF;
            r_ir     <= 32'd0;
            r_br     <= 1'b0;
            PCSrc    <= 1'b0;
            RegWrite <= 1'b0;
            loadPC   <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
        end else begin
            PCSrc    <= 1'b0;
            RegWrite <= 1'b0;
            loadPC   <= 1'b0;
            case (r_state)
                S_IF: begin
                    r_ir    <= instr;
                    r_br    <= 1'b0;
                    r_state <= S_ID;
                end
                S_ID: r_state <= S_EX;
                S_EX: begin
                    r_br     <= (w_class == C_BEQ) && Zero;
                    MemRead  <= (w_class == C_LW);
                    MemWrite <= (w_class == C_SW);
                    r_state  <= S_MEM;
                end
                S_MEM: begin
                    // Memory classes wait on dReady; everything else passes through
                    if (!w_is_mem || dReady) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        loadPC   <= 1'b1;
                        PCSrc    <= r_br;
                        RegWrite <= (w_class == C_R) || (w_class == C_I) ||
                                    (w_class == C_LW);
                        r_state  <= S_WB;
                    end
                end
                S_WB:    r_state <= S_IF;
                default: r_state <= S_IF;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret   <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (r_state == S_WB)
                instret <= instret + 32'd1;
            if (r_state == S_MEM && !dReady)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-instruction
// expectations, a negedge monitor accumulates observations and checks on loadPC.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        dReady;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
    logic [3:0]  ALUCtrl;

    multicycle_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .Zero     (Zero),
        .dReady   (dReady),
        .PCSrc    (PCSrc),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .MemToReg (MemToReg),
        .loadPC   (loadPC),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ALUCtrl  (ALUCtrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        int          lat;
        logic [3:0]  alu;
        logic        asrc;
        logic        m2r;
        logic        rw;
        logic        pcs;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   running = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference: what the unit should do for one instruction, from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, input logic z, input int stall);
        exp_t       e;
        logic [3:0] tab [8];
        logic [2:0] f3;
        logic       f7;
        tab = '{4'b0010, 4'b1001, 4'b0111, 4'b0111, 4'b1101, 4'b1000, 4'b0001, 4'b0000};
        f3  = ins[14:12];
        f7  = ins[30];
        e = '{ins: ins, lat: 5, alu: 4'b0010, asrc: 1'b0, m2r: 1'b0, rw: 1'b0,
              pcs: 1'b0, nrd: 0, nwr: 0};
        case (ins[6:0])
            7'b0110011: begin
                e.rw  = 1'b1;
                e.alu = tab[f3];
                if (f7 && f3 == 3'd0) e.alu = 4'b0110;
                if (f7 && f3 == 3'd5) e.alu = 4'b1010;
            end
            7'b0010011: begin
                e.rw   = 1'b1;
                e.asrc = 1'b1;
                e.alu  = tab[f3];
                if (f7 && f3 == 3'd5) e.alu = 4'b1010;
            end
            7'b0000011: begin
                e.rw = 1'b1; e.asrc = 1'b1; e.m2r = 1'b1;
                e.lat = 5 + stall; e.nrd = stall + 1;
            end
            7'b0100011: begin
                e.asrc = 1'b1;
                e.lat = 5 + stall; e.nwr = stall + 1;
            end
            7'b1100011: begin
                e.alu = 4'b0110;
                e.pcs = z;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor state
    int         cyc, rd_c, wr_c, rw_c;
    logic       if_bad, dec_bad, excl_bad, pcs_bad;
    logic [5:0] dec_seen;

    task automatic clear_obs();
        cyc = 0; rd_c = 0; wr_c = 0; rw_c = 0;
        if_bad = 1'b0; dec_bad = 1'b0; excl_bad = 1'b0; pcs_bad = 1'b0;
        dec_seen = 6'd0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            clear_obs();
        end else if (running) begin
            exp_t e;
            cyc++;
            if (q.size() == 0) begin
                if (loadPC) check("spurious_loadPC", 32'(loadPC), 32'd0);
            end else begin
                e = q[0];
                if (cyc == 1) begin
                    if (ALUCtrl !== 4'd0 || ALUSrc !== 1'b0 || MemToReg !== 1'b0) begin
                        if_bad = 1'b1;
                        dec_seen = {ALUSrc, MemToReg, ALUCtrl};
                    end
                end else if (ALUCtrl !== e.alu || ALUSrc !== e.asrc || MemToReg !== e.m2r) begin
                    dec_bad = 1'b1;
                    dec_seen = {ALUSrc, MemToReg, ALUCtrl};
                end
                rd_c += int'(MemRead);
                wr_c += int'(MemWrite);
                rw_c += int'(RegWrite);
                if ($countones({MemRead, MemWrite, RegWrite}) > 1) excl_bad = 1'b1;
                if (PCSrc && !loadPC) pcs_bad = 1'b1;
                if (loadPC) begin
                    check("latency",       32'(cyc), 32'(e.lat));
                    check("wb_RegWrite",   32'(RegWrite), 32'(e.rw));
                    check("wb_PCSrc",      32'(PCSrc), 32'(e.pcs));
                    check("MemRead_cycles",  32'(rd_c), 32'(e.nrd));
                    check("MemWrite_cycles", 32'(wr_c), 32'(e.nwr));
                    check("RegWrite_cycles", 32'(rw_c), 32'(e.rw));
                    check("decode_ID_WB",  32'(dec_bad ? dec_seen : 6'd0),
                                           32'(dec_bad ? {e.asrc, e.m2r, e.alu} : 6'd0));
                    check("decode_IF_zero", 32'(if_bad ? dec_seen : 6'd0), 32'd0);
                    check("strobe_exclusive", 32'(excl_bad), 32'd0);
                    check("PCSrc_outside_WB", 32'(pcs_bad), 32'd0);
                    void'(q.pop_front());
                    clear_obs();
                end else if (cyc > 40) begin
                    check("wb_timeout", 32'(cyc), 32'(e.lat));
                    void'(q.pop_front());
                    clear_obs();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction starting in IF; dReady low for 'stall' MEM cycles
    task automatic run_instr(input logic [31:0] ins, input logic z, input int stall);
        q.push_back(model(ins, z, stall));
        instr  = ins;
        Zero   = z;
        dReady = 1'($urandom);
        step();                            // ID
        dReady = 1'($urandom);
        step();                            // EX
        step();                            // MEM
        if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) begin
            for (int k = 0; k <= stall; k++) begin
                dReady = (k == stall);
                step();
            end
        end else begin
            dReady = 1'($urandom);
            step();
        end
        dReady = 1'($urandom);             // WB
        step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] body;
        logic [6:0]  opc;
        body = $urandom;
        case ($urandom_range(0, 5))
            0: opc = 7'b0110011;
            1: opc = 7'b0010011;
            2: opc = 7'b0000011;
            3: opc = 7'b0100011;
            4: opc = 7'b1100011;
            default: begin
                opc = 7'($urandom_range(0, 127));
                while (opc == 7'b0110011 || opc == 7'b0010011 || opc == 7'b0000011 ||
                       opc == 7'b0100011 || opc == 7'b1100011)
                    opc = 7'($urandom_range(0, 127));
            end
        endcase
        return {body[31:7], opc};
    endfunction

    initial begin
        rst = 1'b1; instr = 32'd0; Zero = 1'b0; dReady = 1'b0;
        clear_obs();
        step();
        step();
        check("reset_outputs",
              32'({PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, ALUCtrl}), 32'd0);
        rst = 1'b0;
        running = 1'b1;

        // Reset in the middle of an LW that is waiting on dReady
        q.push_back(model(32'h0080A383, 1'b0, 0));
        instr = 32'h0080A383; Zero = 1'b0; dReady = 1'b0;
        step(); step(); step(); step(); step();       // MEM, third wait cycle
        check("lw_wait_MemRead", 32'(MemRead), 32'd1);
        rst = 1'b1;
        q.delete();
        #1;
        check("rst_midmem_strobes", 32'({MemRead, MemWrite, RegWrite, loadPC}), 32'd0);
        step();
        rst = 1'b0;

        run_instr(32'h002081B3, 1'b0, 0);   // ADD x3,x1,x2
        run_instr(32'h40335293, 1'b1, 0);   // SRAI x5,x6,3
        run_instr(32'h00335293, 1'b0, 0);   // SRLI
        run_instr(32'h0080A383, 1'b0, 3);   // LW, 3 stall cycles
        run_instr(32'h0070A423, 1'b1, 3);   // SW, 3 stall cycles
        run_instr(32'h00208463, 1'b1, 0);   // BEQ taken
        run_instr(32'h00208463, 1'b0, 0);   // BEQ not taken
        run_instr(32'h0000007F, 1'b1, 0);   // illegal opcode
        run_instr(32'h40208233, 1'b0, 0);   // SUB
        run_instr(32'h0080A383, 1'b0, 0);   // LW, no stall

        for (int n = 0; n < 60; n++)
            run_instr(rand_instr(), 1'($urandom), $urandom_range(0, 3));

        for (int w = 0; w < 50 && q.size() != 0; w++) step();
        if (q.size() != 0) check("drain_queue", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
